// File: rtl/riscv_axi_pkg.sv
// Shared definitions for the RISC-V memory arbiter: FSM states, owner tags and
// the AXI response constant.
package riscv_axi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_AR   = 3'd1,
        ST_RD_R    = 3'd2,
        ST_WR_AW_W = 3'd3,
        ST_WR_B    = 3'd4
    } arb_state_e;

    typedef enum logic {
        OWN_INST = 1'b0,
        OWN_DATA = 1'b1
    } owner_e;

    localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

endpackage

// File: rtl/riscv_mem_arbiter.sv
// Arbitrates instruction-fetch and load/store requests onto a single AXI master,
// one transaction in flight, round-robin when both ports request together.
module riscv_mem_arbiter
    import riscv_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  riscv_cpu_clk,
    input  logic                  riscv_cpu_reset_n,

    input  logic                  inst_req_valid,
    output logic                  inst_req_ready,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic [DATA_W-1:0]     inst_rdata,
    output logic                  inst_rvalid,
    input  logic                  inst_rready,

    input  logic                  data_req_valid,
    input  logic                  data_we,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    output logic                  data_req_ready,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  data_rvalid,
    input  logic                  data_rready,
    output logic                  data_wdone,

    output logic                  mem_err,

    output logic [ADDR_W-1:0]     riscv_cpu_axi_if_araddr,
    output logic                  riscv_cpu_axi_if_arvalid,
    input  logic                  riscv_cpu_axi_if_arready,
    input  logic [DATA_W-1:0]     riscv_cpu_axi_if_rdata,
    input  logic                  riscv_cpu_axi_if_rvalid,
    output logic                  riscv_cpu_axi_if_rready,
    input  logic [1:0]            riscv_cpu_axi_if_rresp,
    output logic [ADDR_W-1:0]     riscv_cpu_axi_if_awaddr,
    output logic                  riscv_cpu_axi_if_awvalid,
    input  logic                  riscv_cpu_axi_if_awready,
    output logic [DATA_W-1:0]     riscv_cpu_axi_if_wdata,
    output logic [DATA_W/8-1:0]   riscv_cpu_axi_if_wstrb,
    output logic                  riscv_cpu_axi_if_wvalid,
    input  logic                  riscv_cpu_axi_if_wready,
    input  logic                  riscv_cpu_axi_if_bvalid,
    output logic                  riscv_cpu_axi_if_bready,
    input  logic [1:0]            riscv_cpu_axi_if_bresp
);

    arb_state_e            state_q, state_d;
    owner_e                owner_q, owner_d;
    owner_e                last_q, last_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic                  aw_pend_q, aw_pend_d;
    logic                  w_pend_q, w_pend_d;
    logic                  mem_err_q, mem_err_d;
    logic                  wdone_q, wdone_d;

    logic                  grant_inst, grant_data;
    logic                  owner_rready;

    // Grant only in IDLE; on a tie the port not served last wins.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state_q == ST_IDLE) begin
            if (inst_req_valid && data_req_valid) begin
                grant_data = (last_q == OWN_INST);
                grant_inst = (last_q == OWN_DATA);
            end else begin
                grant_inst = inst_req_valid;
                grant_data = data_req_valid;
            end
        end
    end

    assign owner_rready = (owner_q == OWN_INST) ? inst_rready : data_rready;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        aw_pend_d = aw_pend_q;
        w_pend_d  = w_pend_q;
        mem_err_d = 1'b0;
        wdone_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (grant_data) begin
                    owner_d = OWN_DATA;
                    last_d  = OWN_DATA;
                    addr_d  = data_addr;
                    wdata_d = data_wdata;
                    wstrb_d = data_wstrb;
                    if (data_we) begin
                        state_d   = ST_WR_AW_W;
                        aw_pend_d = 1'b1;
                        w_pend_d  = 1'b1;
                    end else begin
                        state_d = ST_RD_AR;
                    end
                end else if (grant_inst) begin
                    owner_d = OWN_INST;
                    last_d  = OWN_INST;
                    addr_d  = inst_addr;
                    wdata_d = '0;
                    wstrb_d = '0;
                    state_d = ST_RD_AR;
                end
            end
            ST_RD_AR: begin
                if (riscv_cpu_axi_if_arready) state_d = ST_RD_R;
            end
            ST_RD_R: begin
                if (riscv_cpu_axi_if_rvalid && owner_rready) begin
                    state_d   = ST_IDLE;
                    mem_err_d = (riscv_cpu_axi_if_rresp != AXI_RESP_OKAY);
                end
            end
            ST_WR_AW_W: begin
                // AW and W retire independently; move on once both are accepted.
                aw_pend_d = aw_pend_q & ~riscv_cpu_axi_if_awready;
                w_pend_d  = w_pend_q & ~riscv_cpu_axi_if_wready;
                if (!aw_pend_d && !w_pend_d) state_d = ST_WR_B;
            end
            ST_WR_B: begin
                if (riscv_cpu_axi_if_bvalid) begin
                    state_d   = ST_IDLE;
                    wdone_d   = 1'b1;
                    mem_err_d = (riscv_cpu_axi_if_bresp != AXI_RESP_OKAY);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge riscv_cpu_clk or negedge riscv_cpu_reset_n) begin
        if (!riscv_cpu_reset_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_INST;
            last_q    <= OWN_INST;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            mem_err_q <= 1'b0;
            wdone_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            last_q    <= last_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            aw_pend_q <= aw_pend_d;
            w_pend_q  <= w_pend_d;
            mem_err_q <= mem_err_d;
            wdone_q   <= wdone_d;
        end
    end

    // Grant readies are combinational on the request valids, so gate them
    // with reset to keep every ready low while reset is held.
    assign inst_req_ready = grant_inst & riscv_cpu_reset_n;
    assign data_req_ready = grant_data & riscv_cpu_reset_n;

    assign riscv_cpu_axi_if_araddr  = addr_q;
    assign riscv_cpu_axi_if_arvalid = (state_q == ST_RD_AR);
    assign riscv_cpu_axi_if_rready  = (state_q == ST_RD_R) & owner_rready;

    assign riscv_cpu_axi_if_awaddr  = addr_q;
    assign riscv_cpu_axi_if_awvalid = (state_q == ST_WR_AW_W) & aw_pend_q;
    assign riscv_cpu_axi_if_wdata   = wdata_q;
    assign riscv_cpu_axi_if_wstrb   = wstrb_q;
    assign riscv_cpu_axi_if_wvalid  = (state_q == ST_WR_AW_W) & w_pend_q;
    assign riscv_cpu_axi_if_bready  = (state_q == ST_WR_B);

    assign inst_rvalid = (state_q == ST_RD_R) && (owner_q == OWN_INST) && riscv_cpu_axi_if_rvalid;
    assign data_rvalid = (state_q == ST_RD_R) && (owner_q == OWN_DATA) && riscv_cpu_axi_if_rvalid;
    assign inst_rdata  = ((state_q == ST_RD_R) && (owner_q == OWN_INST)) ? riscv_cpu_axi_if_rdata : '0;
    assign data_rdata  = ((state_q == ST_RD_R) && (owner_q == OWN_DATA)) ? riscv_cpu_axi_if_rdata : '0;

    assign data_wdone = wdone_q;
    assign mem_err    = mem_err_q;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// Directed bench for riscv_mem_arbiter: fetch, round-robin, stores, error
// response, reset mid-read and read backpressure.
module tb_riscv_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_req_valid, inst_req_ready, inst_rvalid, inst_rready;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req_valid, data_we, data_req_ready, data_rvalid, data_rready, data_wdone;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wstrb;
    logic        mem_err;
    logic [31:0] araddr, rdata, awaddr, wdata;
    logic        arvalid, arready, rvalid, rready, awvalid, awready, wvalid, wready, bvalid, bready;
    logic [1:0]  rresp, bresp;
    logic [3:0]  wstrb;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    riscv_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .riscv_cpu_clk            (clk),
        .riscv_cpu_reset_n        (rst_n),
        .inst_req_valid           (inst_req_valid),
        .inst_req_ready           (inst_req_ready),
        .inst_addr                (inst_addr),
        .inst_rdata               (inst_rdata),
        .inst_rvalid              (inst_rvalid),
        .inst_rready              (inst_rready),
        .data_req_valid           (data_req_valid),
        .data_we                  (data_we),
        .data_addr                (data_addr),
        .data_wdata               (data_wdata),
        .data_wstrb               (data_wstrb),
        .data_req_ready           (data_req_ready),
        .data_rdata               (data_rdata),
        .data_rvalid              (data_rvalid),
        .data_rready              (data_rready),
        .data_wdone               (data_wdone),
        .mem_err                  (mem_err),
        .riscv_cpu_axi_if_araddr  (araddr),
        .riscv_cpu_axi_if_arvalid (arvalid),
        .riscv_cpu_axi_if_arready (arready),
        .riscv_cpu_axi_if_rdata   (rdata),
        .riscv_cpu_axi_if_rvalid  (rvalid),
        .riscv_cpu_axi_if_rready  (rready),
        .riscv_cpu_axi_if_rresp   (rresp),
        .riscv_cpu_axi_if_awaddr  (awaddr),
        .riscv_cpu_axi_if_awvalid (awvalid),
        .riscv_cpu_axi_if_awready (awready),
        .riscv_cpu_axi_if_wdata   (wdata),
        .riscv_cpu_axi_if_wstrb   (wstrb),
        .riscv_cpu_axi_if_wvalid  (wvalid),
        .riscv_cpu_axi_if_wready  (wready),
        .riscv_cpu_axi_if_bvalid  (bvalid),
        .riscv_cpu_axi_if_bready  (bready),
        .riscv_cpu_axi_if_bresp   (bresp)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One read with immediate arready/rvalid; vi/vd select requesters, exp_d is the expected winner.
    task automatic rd_txn(input logic vi, input logic vd, input logic exp_d, input logic [31:0] rd);
        inst_req_valid = vi; inst_addr = 32'h200;
        data_req_valid = vd; data_we = 1'b0; data_addr = 32'h8000;
        #1;
        chk("gnt_data", data_req_ready, exp_d);
        chk("gnt_inst", inst_req_ready, !exp_d);
        tick();
        inst_req_valid = 1'b0; data_req_valid = 1'b0; arready = 1'b1;
        #1;
        chk("rr_arvalid", arvalid, 1'b1);
        chk("rr_araddr", araddr, exp_d ? 32'h8000 : 32'h200);
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = rd; inst_rready = 1'b1; data_rready = 1'b1;
        #1;
        chk("rr_data_rvalid", data_rvalid, exp_d);
        chk("rr_inst_rvalid", inst_rvalid, !exp_d);
        chk("rr_rdata", exp_d ? data_rdata : inst_rdata, rd);
        tick();
        rvalid = 1'b0;
        #1;
        chk("rr_done_inst_rvalid", inst_rvalid, 1'b0);
        chk("rr_done_data_rvalid", data_rvalid, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        inst_req_valid = 1'b1; inst_addr = '0; inst_rready = 1'b0;
        data_req_valid = 1'b1; data_we = 1'b0; data_addr = '0; data_wdata = '0; data_wstrb = '0;
        data_rready = 1'b0;
        arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        #2;
        // Reset state: readies gated even with both requests up.
        chk("rst_inst_ready", inst_req_ready, 1'b0);
        chk("rst_data_ready", data_req_ready, 1'b0);
        chk("rst_arvalid", arvalid, 1'b0);
        chk("rst_awvalid", awvalid, 1'b0);
        chk("rst_wvalid", wvalid, 1'b0);
        chk("rst_bready", bready, 1'b0);
        chk("rst_araddr", araddr, 32'h0);
        chk("rst_mem_err", mem_err, 1'b0);
        chk("rst_wdone", data_wdone, 1'b0);
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Fetch at 0x100, arready after 2 cycles.
        inst_req_valid = 1'b1; inst_addr = 32'h100;
        #1;
        chk("f_inst_ready", inst_req_ready, 1'b1);
        chk("f_data_ready", data_req_ready, 1'b0);
        tick();
        inst_req_valid = 1'b0; data_req_valid = 1'b1; data_addr = 32'h44;
        #1;
        chk("f_arvalid_g1", arvalid, 1'b1);
        chk("f_araddr", araddr, 32'h100);
        chk("f_busy_ignores_data", data_req_ready, 1'b0);
        chk("f_inst_ready_busy", inst_req_ready, 1'b0);
        data_req_valid = 1'b0;
        tick();
        #1;
        chk("f_arvalid_hold", arvalid, 1'b1);
        chk("f_araddr_hold", araddr, 32'h100);
        arready = 1'b1;
        tick();
        arready = 1'b0; inst_rready = 1'b1; rvalid = 1'b1; rdata = 32'h00000013;
        #1;
        chk("f_arvalid_off", arvalid, 1'b0);
        chk("f_rready", rready, 1'b1);
        chk("f_inst_rvalid", inst_rvalid, 1'b1);
        chk("f_inst_rdata", inst_rdata, 32'h00000013);
        chk("f_data_rvalid", data_rvalid, 1'b0);
        tick();
        rvalid = 1'b0;
        #1;
        chk("f_idle_rready", rready, 1'b0);
        chk("f_mem_err", mem_err, 1'b0);

        // Round-robin from a fresh reset: data, inst, data, inst.
        rst_n = 1'b0; #1; rst_n = 1'b1;
        tick();
        rd_txn(1'b1, 1'b1, 1'b1, 32'hA0A0_0001);
        rd_txn(1'b1, 1'b1, 1'b0, 32'hA0A0_0002);
        rd_txn(1'b1, 1'b1, 1'b1, 32'hA0A0_0003);
        rd_txn(1'b1, 1'b1, 1'b0, 32'hA0A0_0004);

        // Store, wready three cycles ahead of awready.
        data_req_valid = 1'b1; data_we = 1'b1; data_addr = 32'h4;
        data_wdata = 32'hDEADBEEF; data_wstrb = 4'b0011;
        #1;
        chk("s_data_ready", data_req_ready, 1'b1);
        tick();
        data_req_valid = 1'b0; data_we = 1'b0;
        #1;
        chk("s_awvalid", awvalid, 1'b1);
        chk("s_wvalid", wvalid, 1'b1);
        chk("s_awaddr", awaddr, 32'h4);
        chk("s_wdata", wdata, 32'hDEADBEEF);
        chk("s_wstrb", wstrb, 4'b0011);
        wready = 1'b1;
        tick();
        wready = 1'b0;
        #1;
        chk("s_wvalid_drop", wvalid, 1'b0);
        chk("s_awvalid_keep", awvalid, 1'b1);
        chk("s_bready_early", bready, 1'b0);
        tick();
        tick();
        #1;
        chk("s_awvalid_keep2", awvalid, 1'b1);
        chk("s_awaddr_stable", awaddr, 32'h4);
        chk("s_bready_early2", bready, 1'b0);
        awready = 1'b1;
        tick();
        awready = 1'b0;
        #1;
        chk("s_awvalid_drop", awvalid, 1'b0);
        chk("s_bready", bready, 1'b1);
        chk("s_wdone_early", data_wdone, 1'b0);
        bvalid = 1'b1; bresp = 2'b00;
        tick();
        bvalid = 1'b0;
        #1;
        chk("s_wdone_pulse", data_wdone, 1'b1);
        chk("s_mem_err_ok", mem_err, 1'b0);
        chk("s_bready_off", bready, 1'b0);
        tick();
        #1;
        chk("s_wdone_once", data_wdone, 1'b0);

        // Store with simultaneous AW/W handshake and SLVERR response.
        data_req_valid = 1'b1; data_we = 1'b1; data_addr = 32'h10;
        data_wdata = 32'h1234_5678; data_wstrb = 4'b1111;
        tick();
        data_req_valid = 1'b0; data_we = 1'b0; awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        #1;
        chk("e_bready_both", bready, 1'b1);
        chk("e_awvalid_off", awvalid, 1'b0);
        bvalid = 1'b1; bresp = 2'b10;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        #1;
        chk("e_mem_err", mem_err, 1'b1);
        chk("e_wdone", data_wdone, 1'b1);
        inst_req_valid = 1'b1; inst_addr = 32'h300;
        #1;
        chk("e_idle_grant", inst_req_ready, 1'b1);
        inst_req_valid = 1'b0;
        tick();
        #1;
        chk("e_mem_err_once", mem_err, 1'b0);
        chk("e_idle_arvalid", arvalid, 1'b0);

        // Read backpressure: rvalid held while inst_rready is low for 4 cycles.
        inst_req_valid = 1'b1; inst_addr = 32'h400;
        tick();
        inst_req_valid = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; inst_rready = 1'b0; rvalid = 1'b1; rdata = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_rready", rready, 1'b0);
            chk("bp_inst_rvalid", inst_rvalid, 1'b1);
            chk("bp_inst_rdata", inst_rdata, 32'hCAFE_0001);
            tick();
        end
        inst_rready = 1'b1;
        #1;
        chk("bp_rready_on", rready, 1'b1);
        tick();
        rvalid = 1'b0;
        #1;
        chk("bp_done", inst_rvalid, 1'b0);

        // Reset asserted while in RD_R, then a fresh fetch.
        inst_req_valid = 1'b1; inst_addr = 32'h500;
        tick();
        inst_req_valid = 1'b0; arready = 1'b1;
        tick();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h5555_AAAA; inst_rready = 1'b1;
        #1;
        chk("r_pre_rvalid", inst_rvalid, 1'b1);
        inst_req_valid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("r_inst_rvalid", inst_rvalid, 1'b0);
        chk("r_rready", rready, 1'b0);
        chk("r_inst_rdata", inst_rdata, 32'h0);
        chk("r_inst_ready", inst_req_ready, 1'b0);
        chk("r_araddr", araddr, 32'h0);
        inst_req_valid = 1'b0; rvalid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        rd_txn(1'b1, 1'b0, 1'b0, 32'h0000_0013);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        bad++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule

// File: doc/riscv_mem_arbiter.md
RISCV_MEM_ARBITER -- requirements
Module: riscv_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32: address width of both request ports and the AXI address channels.
REQ-002 SHALL have parameter DATA_W, default 32: data width; the write strobe width is DATA_W/8.
REQ-003 SHALL have port riscv_cpu_clk, input, 1: single clock; all logic is rising-edge.
REQ-004 SHALL have port riscv_cpu_reset_n, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have ports inst_req_valid in 1, inst_req_ready out 1, inst_addr in ADDR_W: instruction fetch request.
REQ-006 SHALL have ports inst_rdata out DATA_W, inst_rvalid out 1, inst_rready in 1: instruction return.
REQ-007 SHALL have ports data_req_valid in 1, data_we in 1, data_addr in ADDR_W, data_wdata in DATA_W, data_wstrb in DATA_W/8, data_req_ready out 1: load/store request.
REQ-008 SHALL have ports data_rdata out DATA_W, data_rvalid out 1, data_rready in 1, data_wdone out 1: load return and store completion.
REQ-009 SHALL have port mem_err, output, 1: one-cycle pulse on a non-OKAY response.
REQ-010 SHALL have AXI master ports araddr/arvalid/arready, rdata/rvalid/rready/rresp, awaddr/awvalid/awready, wdata/wstrb/wvalid/wready, bvalid/bready/bresp, all prefixed riscv_cpu_axi_if_ with standard directions and widths.

Function
REQ-011 SHALL implement an FSM with states IDLE, RD_AR, RD_R, WR_AW_W, WR_B; one transaction outstanding at a time.
REQ-012 In IDLE, SHALL grant one requester combinationally: inst_req_ready or data_req_ready is 1 in the same cycle as the granted valid; both are 0 outside IDLE.
REQ-013 When both requests are valid in IDLE, SHALL grant round-robin to the requester not granted last; after reset the data port wins first.
REQ-014 On grant, SHALL register the address, write data, strobe and owner; next state is RD_AR (inst, or data with data_we=0) or WR_AW_W (data with data_we=1).
REQ-015 In RD_AR, arvalid SHALL be 1 with the registered address, one cycle after grant; on arready the FSM goes to RD_R.
REQ-016 In RD_R, rready SHALL equal the owner's rready; the owner's rvalid SHALL equal riscv_cpu_axi_if_rvalid and its rdata SHALL equal rdata, combinationally; the non-owner's rvalid SHALL be 0. On the R handshake the FSM goes to IDLE.
REQ-017 In WR_AW_W, awvalid and wvalid SHALL both be asserted the cycle after grant; each deasserts independently on its own handshake, and simultaneous awready and wready in one cycle completes both.
REQ-018 When both the AW and W handshakes are done, SHALL go to WR_B with bready=1.
REQ-019 On bvalid in WR_B, data_wdone SHALL pulse for one cycle and the FSM goes to IDLE.
REQ-020 SHALL hold every AXI payload stable while its valid is 1 and not accepted; valid SHALL never drop before the handshake.
REQ-021 mem_err SHALL pulse in the cycle after an R or B handshake carrying resp != 2'b00; the data is still delivered.
REQ-022 Requests arriving outside IDLE SHALL be ignored until IDLE; no request buffering.

Reset
REQ-023 Assertion of riscv_cpu_reset_n=0 SHALL immediately force state IDLE, all valid/ready outputs 0, all payload registers 0, mem_err 0, data_wdone 0, and the round-robin pointer to "inst last".
REQ-024 Reset mid-transaction SHALL abandon the transaction; the interconnect is reset jointly.

Structure
REQ-025 FSM state encodings and the AXI OKAY constant SHALL reside in a shared package riscv_axi_pkg.
REQ-026 Single module; no sub-module is required.

Verification
REQ-027 Fetch: inst_addr=0x100, arready=1 after 2 cycles, rdata=0x00000013 -> arvalid at grant+1, araddr=0x100, inst_rvalid with 0x00000013, data_rvalid=0.
REQ-028 Simultaneous inst 0x200 and data load 0x8000 twice -> grant order data, inst, data, inst.
REQ-029 Store addr=0x4, wdata=0xDEADBEEF, wstrb=4'b0011; wready 3 cycles before awready -> wvalid drops first, bready=1 only after both handshakes, data_wdone pulses once.
REQ-030 bresp=2'b10 on a store -> mem_err=1 for exactly one cycle, FSM back in IDLE.
REQ-031 Reset asserted in RD_R -> all outputs 0 asynchronously; after release a fresh fetch completes normally.
REQ-032 rvalid held with inst_rready=0 for 4 cycles -> rready=0, state stays RD_R, rdata is passed through unchanged.
